ps2_mouse_axil_slave: RTL and testbench

//  AXI4-Lite slave holding the PS/2 mouse register file. Consumes decoded PS/2 bytes

---
 rtl/ps2_axil_pkg.sv | 45 ++++
 rtl/ps2_packet_assembler.sv | 52 +++++
 rtl/ps2_mouse_axil_slave.sv | 170 +++++++++++++++++
 tb/tb_ps2_mouse_axil_slave.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_axil_pkg.sv
// Shared definitions for the PS/2 mouse AXI4-Lite register block: register map,
// response codes, STATE field layout, FSM state types and the position clamp.
package ps2_axil_pkg;

  localparam logic [7:0] REG_CTRL  = 8'h00;
  localparam logic [7:0] REG_STAT  = 8'h01;
  localparam logic [7:0] REG_STATE = 8'h02;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam int unsigned STATE_X_LSB   = 0;
  localparam int unsigned STATE_Y_LSB   = 12;
  localparam int unsigned STATE_BTN_LSB = 24;
  localparam int unsigned STATE_OVF_BIT = 27;

  typedef enum logic {R_IDLE, R_DATA} r_state_e;
  typedef enum logic [1:0] {W_IDLE, W_ACK, W_RESP} w_state_e;
  typedef enum logic [1:0] {B0, B1, B2} asm_state_e;

  // Adds a 9-bit signed delta in 14-bit arithmetic and clamps to [0, max].
  function automatic logic [11:0] clamp_add(input logic [11:0] pos, input logic [8:0] d,
                                            input logic [11:0] max);
    logic [13:0] sum;
    sum = {2'b00, pos} + {{5{d[8]}}, d};
    if (sum[13]) begin
      return 12'd0;
    end else if (sum[12:0] > {1'b0, max}) begin
      return max;
    end
    return sum[11:0];
  endfunction

  function automatic logic [31:0] pack_state(input logic [11:0] x, input logic [11:0] y,
                                             input logic [2:0] btn, input logic ovf);
    logic [31:0] w;
    w = '0;
    w[STATE_X_LSB +: 12]   = x;
    w[STATE_Y_LSB +: 12]   = y;
    w[STATE_BTN_LSB +: 3]  = btn;
    w[STATE_OVF_BIT]       = ovf;
    return w;
  endfunction

endpackage

// File: rtl/ps2_packet_assembler.sv
// Frames the PS/2 byte stream into 3-byte mouse packets; pkt_valid pulses while the
// third byte is on rx_data so the consumer commits on that same edge.
module ps2_packet_assembler
  import ps2_axil_pkg::*;
(
  input  logic       ACLK,
  input  logic       reset,
  input  logic       rx_valid,
  input  logic [7:0] rx_data,
  output logic       pkt_valid,
  output logic [8:0] dx,
  output logic [8:0] dy,
  output logic [2:0] btn,
  output logic       ovx,
  output logic       ovy
);

  asm_state_e state_q, state_d;
  logic [7:0] b0_q, b1_q;

  always_comb begin
    state_d = state_q;
    if (rx_valid) begin
      unique case (state_q)
        B0:      if (rx_data[3]) state_d = B1;  // bit3 is always set in a header byte
        B1:      state_d = B2;
        B2:      state_d = B0;
        default: state_d = B0;
      endcase
    end
  end

  always_ff @(posedge ACLK or posedge reset) begin
    if (reset) begin
      state_q <= B0;
      b0_q    <= '0;
      b1_q    <= '0;
    end else begin
      state_q <= state_d;
      if (rx_valid && state_q == B0) b0_q <= rx_data;
      if (rx_valid && state_q == B1) b1_q <= rx_data;
    end
  end

  assign pkt_valid = rx_valid && (state_q == B2);
  assign dx        = {b0_q[4], b1_q};
  assign dy        = {b0_q[5], rx_data};
  assign btn       = b0_q[2:0];
  assign ovx       = b0_q[6];
  assign ovy       = b0_q[7];

endmodule

// File: rtl/ps2_mouse_axil_slave.sv
// AXI4-Lite register file for a PS/2 mouse: integrates packet deltas into clamped
// absolute X/Y and serves CTRL/STAT/STATE to the polling master.
module ps2_mouse_axil_slave
  import ps2_axil_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned X_MAX      = 639,
  parameter int unsigned Y_MAX      = 479
) (
  input  logic                    ACLK,
  input  logic                    reset,
  input  logic                    rx_valid,
  input  logic [7:0]              rx_data,
  input  logic [ADDR_WIDTH-1:0]   AWADDR,
  input  logic [2:0]              AWPROT,
  input  logic                    AWVALID,
  output logic                    AWREADY,
  input  logic [DATA_WIDTH-1:0]   WDATA,
  input  logic [DATA_WIDTH/8-1:0] WSTRB,
  input  logic                    WVALID,
  output logic                    WREADY,
  output logic [1:0]              BRESP,
  output logic                    BVALID,
  input  logic                    BREADY,
  input  logic [ADDR_WIDTH-1:0]   ARADDR,
  input  logic [2:0]              ARPROT,
  input  logic                    ARVALID,
  output logic                    ARREADY,
  output logic [DATA_WIDTH-1:0]   RDATA,
  output logic [1:0]              RRESP,
  output logic                    RVALID,
  input  logic                    RREADY
);

  logic       pkt_valid, ovx, ovy;
  logic [8:0] dx, dy;
  logic [2:0] btn;

  ps2_packet_assembler u_asm (
    .ACLK      (ACLK),
    .reset     (reset),
    .rx_valid  (rx_valid),
    .rx_data   (rx_data),
    .pkt_valid (pkt_valid),
    .dx        (dx),
    .dy        (dy),
    .btn       (btn),
    .ovx       (ovx),
    .ovy       (ovy)
  );

  logic [11:0] x_q, y_q;
  logic [2:0]  btn_q;
  logic        ovf_q, enable_q;
  logic [15:0] pktcnt_q;

  // Write channel
  w_state_e w_state_q, w_state_d;
  logic     wr_fire, ctrl_wr, clear;
  logic [1:0] bresp_q;

  always_comb begin
    w_state_d = w_state_q;
    unique case (w_state_q)
      W_IDLE:  if (AWVALID && WVALID) w_state_d = W_ACK;
      W_ACK:   w_state_d = W_RESP;
      W_RESP:  if (BREADY) w_state_d = W_IDLE;
      default: w_state_d = W_IDLE;
    endcase
  end

  assign wr_fire = (w_state_q == W_ACK);
  assign ctrl_wr = wr_fire && (AWADDR == ADDR_WIDTH'(REG_CTRL)) && WSTRB[0];
  assign clear   = ctrl_wr && WDATA[0];
  assign AWREADY = wr_fire;
  assign WREADY  = wr_fire;
  assign BVALID  = (w_state_q == W_RESP);
  assign BRESP   = bresp_q;

  always_ff @(posedge ACLK or posedge reset) begin
    if (reset) begin
      w_state_q <= W_IDLE;
      bresp_q   <= RESP_OKAY;
      enable_q  <= 1'b1;
    end else begin
      w_state_q <= w_state_d;
      if (wr_fire) begin
        bresp_q <= (AWADDR == ADDR_WIDTH'(REG_CTRL)) ? RESP_OKAY : RESP_SLVERR;
      end
      if (ctrl_wr) enable_q <= WDATA[1];
    end
  end

  // Packet commit; CLEAR overrides position/overflow on a coincident edge.
  always_ff @(posedge ACLK or posedge reset) begin
    if (reset) begin
      x_q      <= '0;
      y_q      <= '0;
      btn_q    <= '0;
      ovf_q    <= 1'b0;
      pktcnt_q <= '0;
    end else begin
      if (pkt_valid && enable_q) begin
        btn_q    <= btn;
        pktcnt_q <= pktcnt_q + 16'd1;
        if (!ovx) x_q <= clamp_add(x_q, dx, 12'(X_MAX));
        if (!ovy) y_q <= clamp_add(y_q, dy, 12'(Y_MAX));
        if (ovx || ovy) ovf_q <= 1'b1;
      end
      if (clear) begin
        x_q   <= '0;
        y_q   <= '0;
        ovf_q <= 1'b0;
      end
    end
  end

  // Read channel
  r_state_e r_state_q, r_state_d;
  logic        arready_q, ar_fire;
  logic [31:0] rd_data, rdata_q;
  logic [1:0]  rd_resp, rresp_q;

  assign ar_fire = (r_state_q == R_IDLE) && ARVALID && arready_q;

  always_comb begin
    r_state_d = r_state_q;
    unique case (r_state_q)
      R_IDLE: if (ar_fire) r_state_d = R_DATA;
      R_DATA: if (RREADY) r_state_d = R_IDLE;
    endcase
  end

  always_comb begin
    rd_data = '0;
    rd_resp = RESP_OKAY;
    case (ARADDR)
      ADDR_WIDTH'(REG_CTRL):  rd_data = {30'd0, enable_q, 1'b0};
      ADDR_WIDTH'(REG_STAT):  rd_data = {16'd0, pktcnt_q};
      ADDR_WIDTH'(REG_STATE): rd_data = pack_state(x_q, y_q, btn_q, ovf_q);
      default:                rd_resp = RESP_SLVERR;
    endcase
  end

  always_ff @(posedge ACLK or posedge reset) begin
    if (reset) begin
      r_state_q <= R_IDLE;
      arready_q <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= RESP_OKAY;
    end else begin
      r_state_q <= r_state_d;
      arready_q <= (r_state_d == R_IDLE);
      if (ar_fire) begin
        rdata_q <= rd_data;
        rresp_q <= rd_resp;
      end
    end
  end

  assign ARREADY = arready_q;
  assign RVALID  = (r_state_q == R_DATA);
  assign RDATA   = DATA_WIDTH'(rdata_q);
  assign RRESP   = rresp_q;

  logic unused_inputs;
  assign unused_inputs = ^{AWPROT, ARPROT, WSTRB[DATA_WIDTH/8-1:1], WDATA[DATA_WIDTH-1:2]};

endmodule

// File: tb/tb_ps2_mouse_axil_slave.sv
// Scoreboard bench for ps2_mouse_axil_slave: stimulus pushes expected responses, a
// negedge monitor pops and compares on every R/B handshake.
module tb_ps2_mouse_axil_slave;

  logic        ACLK = 1'b0;
  logic        reset = 1'b1;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_data = '0;
  logic [7:0]  AWADDR = '0;
  logic [2:0]  AWPROT = '0;
  logic        AWVALID = 1'b0;
  logic        AWREADY;
  logic [31:0] WDATA = '0;
  logic [3:0]  WSTRB = '0;
  logic        WVALID = 1'b0;
  logic        WREADY;
  logic [1:0]  BRESP;
  logic        BVALID;
  logic        BREADY = 1'b0;
  logic [7:0]  ARADDR = '0;
  logic [2:0]  ARPROT = '0;
  logic        ARVALID = 1'b0;
  logic        ARREADY;
  logic [31:0] RDATA;
  logic [1:0]  RRESP;
  logic        RVALID;
  logic        RREADY = 1'b0;

  ps2_mouse_axil_slave dut (
    .ACLK    (ACLK),
    .reset   (reset),
    .rx_valid(rx_valid),
    .rx_data (rx_data),
    .AWADDR  (AWADDR),
    .AWPROT  (AWPROT),
    .AWVALID (AWVALID),
    .AWREADY (AWREADY),
    .WDATA   (WDATA),
    .WSTRB   (WSTRB),
    .WVALID  (WVALID),
    .WREADY  (WREADY),
    .BRESP   (BRESP),
    .BVALID  (BVALID),
    .BREADY  (BREADY),
    .ARADDR  (ARADDR),
    .ARPROT  (ARPROT),
    .ARVALID (ARVALID),
    .ARREADY (ARREADY),
    .RDATA   (RDATA),
    .RRESP   (RRESP),
    .RVALID  (RVALID),
    .RREADY  (RREADY)
  );

  always #5 ACLK = ~ACLK;

  localparam logic [1:0] OK  = 2'b00;
  localparam logic [1:0] ERR = 2'b10;

  int total = 0;
  int bad   = 0;
  logic [33:0] rq[$];
  logic [1:0]  wq[$];
  logic        r_hold = 1'b0;
  logic [33:0] r_prev;

  task automatic chk(input string name, input logic [33:0] act, input logic [33:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  always @(negedge ACLK) begin
    if (reset) begin
      r_hold = 1'b0;
    end else begin
      if (RVALID) begin
        if (r_hold) chk("rdata_stable", {RRESP, RDATA}, r_prev);
        if (RREADY) begin
          r_hold = 1'b0;
          if (rq.size() == 0) chk("unexpected_r", {RRESP, RDATA}, 34'h3_FFFF_FFFF);
          else chk("r_resp_data", {RRESP, RDATA}, rq.pop_front());
        end else begin
          r_hold = 1'b1;
          r_prev = {RRESP, RDATA};
        end
      end
      if (BVALID && BREADY) begin
        if (wq.size() == 0) chk("unexpected_b", {32'd0, BRESP}, 34'h3);
        else chk("bresp", {32'd0, BRESP}, {32'd0, wq.pop_front()});
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    @(posedge ACLK); #1;
    rx_valid = 1'b1;
    rx_data  = b;
    @(posedge ACLK); #1;
    rx_valid = 1'b0;
  endtask

  task automatic send_pkt(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
    send_byte(b0);
    send_byte(b1);
    send_byte(b2);
  endtask

  task automatic rd(input logic [7:0] a, input logic [31:0] ed, input logic [1:0] er,
                    input int hold);
    int n;
    rq.push_back({er, ed});
    @(posedge ACLK); #1;
    ARADDR  = a;
    ARVALID = 1'b1;
    RREADY  = (hold == 0);
    n = 0;
    while (!ARREADY && n < 20) begin
      @(posedge ACLK); #1;
      n++;
    end
    if (n >= 20) chk("arready_timeout", 34'd0, 34'd1);
    @(posedge ACLK); #1;
    ARVALID = 1'b0;
    chk("rvalid_latency", {33'd0, RVALID}, 34'd1);
    if (hold > 0) begin
      repeat (hold) begin
        @(posedge ACLK); #1;
      end
      RREADY = 1'b1;
    end
    n = 0;
    while (RVALID && n < 20) begin
      @(posedge ACLK); #1;
      n++;
    end
    if (n >= 20) chk("rvalid_timeout", 34'd0, 34'd1);
    RREADY = 1'b0;
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s,
                    input logic [1:0] er, input bit with_rx, input logic [7:0] rxb);
    int n;
    wq.push_back(er);
    @(posedge ACLK); #1;
    AWADDR  = a;
    AWVALID = 1'b1;
    WDATA   = d;
    WSTRB   = s;
    WVALID  = 1'b1;
    BREADY  = 1'b1;
    n = 0;
    while (!AWREADY && n < 20) begin
      @(posedge ACLK); #1;
      n++;
    end
    if (n >= 20) chk("awready_timeout", 34'd0, 34'd1);
    // Third packet byte lands on the same edge as the write.
    if (with_rx) begin
      rx_valid = 1'b1;
      rx_data  = rxb;
    end
    @(posedge ACLK); #1;
    AWVALID  = 1'b0;
    WVALID   = 1'b0;
    rx_valid = 1'b0;
    n = 0;
    while (BVALID && n < 20) begin
      @(posedge ACLK); #1;
      n++;
    end
    if (n >= 20) chk("bvalid_timeout", 34'd0, 34'd1);
    BREADY = 1'b0;
  endtask

  task automatic chk_reset_outputs();
    chk("rst_arready", {33'd0, ARREADY}, 34'd0);
    chk("rst_rvalid", {33'd0, RVALID}, 34'd0);
    chk("rst_bvalid", {33'd0, BVALID}, 34'd0);
    chk("rst_awready_wready", {32'd0, AWREADY, WREADY}, 34'd0);
    chk("rst_rdata_rresp_bresp", {RRESP, RDATA}, {32'd0, BRESP});
    chk("rst_rdata", {2'd0, RDATA}, 34'd0);
  endtask

  initial begin
    // 1: reset values
    repeat (3) @(posedge ACLK);
    #1;
    chk_reset_outputs();
    reset = 1'b0;
    rd(8'h02, 32'h0, OK, 0);
    rd(8'h01, 32'h0, OK, 0);
    rd(8'h00, 32'h2, OK, 0);

    // 2: basic motion, then negative deltas clamp at 0
    send_pkt(8'h09, 8'h0A, 8'h05);
    rd(8'h02, 32'h0100_500A, OK, 0);
    rd(8'h01, 32'd1, OK, 0);
    send_pkt(8'h38, 8'hF6, 8'hFB);
    rd(8'h02, 32'h0, OK, 0);
    rd(8'h01, 32'd2, OK, 0);

    // 3: clamp at X_MAX, then X overflow flag
    repeat (3) send_pkt(8'h08, 8'hFF, 8'h00);
    rd(8'h02, 32'h0000_027F, OK, 0);
    send_pkt(8'h08, 8'hFF, 8'h00);
    rd(8'h02, 32'h0000_027F, OK, 0);
    send_pkt(8'h48, 8'h10, 8'h03);
    rd(8'h02, 32'h0800_327F, OK, 0);
    rd(8'h01, 32'd7, OK, 0);

    // 4: clear (keeping enable), then stray byte resync
    wr(8'h00, 32'h3, 4'h1, OK, 1'b0, 8'h00);
    rd(8'h02, 32'h0, OK, 0);
    send_byte(8'h00);
    send_pkt(8'h08, 8'h01, 8'h01);
    rd(8'h02, 32'h0000_1001, OK, 0);
    rd(8'h01, 32'd8, OK, 0);

    // 5: CLEAR (and ENABLE=0) coincident with a commit carrying M button and Y overflow
    send_byte(8'h8C);
    send_byte(8'h05);
    wr(8'h00, 32'h1, 4'h1, OK, 1'b1, 8'h05);
    rd(8'h02, 32'h0400_0000, OK, 0);
    rd(8'h01, 32'd9, OK, 0);
    rd(8'h00, 32'h0, OK, 0);
    send_pkt(8'h08, 8'h01, 8'h01);
    rd(8'h02, 32'h0400_0000, OK, 0);
    rd(8'h01, 32'd9, OK, 0);
    wr(8'h00, 32'h2, 4'h1, OK, 1'b0, 8'h00);
    wr(8'h00, 32'h1, 4'h0, OK, 1'b0, 8'h00);
    rd(8'h00, 32'h2, OK, 0);
    wr(8'h02, 32'h0, 4'hF, ERR, 1'b0, 8'h00);
    wr(8'h10, 32'h1, 4'hF, ERR, 1'b0, 8'h00);
    rd(8'h10, 32'h0, ERR, 0);
    rd(8'h02, 32'h0400_0000, OK, 0);

    // 6: RREADY back-pressure, then reset mid-packet
    rd(8'h01, 32'd9, OK, 5);
    send_byte(8'h08);
    @(posedge ACLK); #1;
    reset = 1'b1;
    #2;
    chk_reset_outputs();
    repeat (2) @(posedge ACLK);
    #1;
    reset = 1'b0;
    send_pkt(8'h08, 8'h02, 8'h02);
    rd(8'h02, 32'h0000_2002, OK, 0);
    rd(8'h01, 32'd1, OK, 0);
    rd(8'h00, 32'h2, OK, 0);

    repeat (3) @(posedge ACLK);
    #1;
    chk("rq_drained", 34'(rq.size()), 34'd0);
    chk("wq_drained", 34'(wq.size()), 34'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
